// File: rtl/fft_frame_sequencer_if.sv
// rtl/fft_frame_sequencer_if.sv - sample-in / framed-out stream bundle of the FFT frame sequencer
interface fft_frame_sequencer_if #(
    parameter int WIDTH = 16
) ();
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_re;
    logic [WIDTH-1:0] s_im;
    logic             m_en;
    logic             m_last;
    logic [WIDTH-1:0] m_re;
    logic [WIDTH-1:0] m_im;

    modport slave (
        input  s_valid, s_re, s_im,
        output s_ready, m_en, m_last, m_re, m_im
    );

    modport master (
        output s_valid, s_re, s_im,
        input  s_ready, m_en, m_last, m_re, m_im
    );
endinterface

// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - input FIFO, credit-gated N-sample burst launcher and output framer for an SDF FFT core
module fft_frame_sequencer #(
    parameter int N          = 64,
    parameter int WIDTH      = 16,
    parameter int FIFO_DEPTH = 128,
    parameter int CREDITS    = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    fft_frame_sequencer_if.slave      strm,
    output logic                      core_di_en,
    output logic [WIDTH-1:0]          core_di_re,
    output logic [WIDTH-1:0]          core_di_im,
    input  logic                      core_do_en,
    input  logic [WIDTH-1:0]          core_do_re,
    input  logic [WIDTH-1:0]          core_do_im,
    input  logic                      credit_return,
    output logic [3:0]                credits,
    output logic [3:0]                inflight,
    output logic                      busy,
    output logic                      err_frame
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = AW + 1;
    localparam int CW = $clog2(N);

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

    state_t                 state_q;
    logic [2*WIDTH-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [FW-1:0]          fill_q, fill_d;
    logic                   s_ready_q;
    logic [CW-1:0]          burst_cnt_q;
    logic                   di_en_q;
    logic [WIDTH-1:0]       di_re_q, di_im_q;
    logic [CW-1:0]          out_cnt_q;
    logic                   m_en_q, m_last_q;
    logic [WIDTH-1:0]       m_re_q, m_im_q;
    logic [3:0]             credits_q, credits_d;
    logic [3:0]             inflight_q, inflight_d;
    logic                   err_q;

    logic                   push, pop, last_pop, can_credit, launch;
    logic                   frame_end, frame_abort, frame_dec, credit_ok;
    logic [2*WIDTH-1:0]     rd_data;

    assign push        = strm.s_valid & s_ready_q;
    assign pop         = (state_q == STREAM);
    assign last_pop    = pop && (burst_cnt_q == CW'(N-1));
    assign can_credit  = enable && (credits_q != 4'd0);
    // A back-to-back relaunch needs N+1 stored: one sample is still leaving this cycle.
    assign launch      = ((state_q == IDLE) && can_credit && (fill_q >= FW'(N))) ||
                         (last_pop && can_credit && (fill_q >= FW'(N+1)));
    assign fill_d      = fill_q + FW'(push) - FW'(pop);
    assign rd_data     = mem[rd_ptr_q];

    assign frame_end   = core_do_en && (out_cnt_q == CW'(N-1));
    assign frame_abort = !core_do_en && (out_cnt_q != '0);
    assign frame_dec   = frame_end || frame_abort;
    assign credit_ok   = credit_return && (credits_q != 4'(CREDITS));

    always_comb begin
        credits_d = credits_q;
        if (launch && !credit_return)
            credits_d = credits_q - 4'd1;
        else if (!launch && credit_ok)
            credits_d = credits_q + 4'd1;
    end

    always_comb begin
        inflight_d = inflight_q;
        if (launch && !frame_dec)
            inflight_d = inflight_q + 4'd1;
        else if (!launch && frame_dec && (inflight_q != 4'd0))
            inflight_d = inflight_q - 4'd1;
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr_q] <= {strm.s_re, strm.s_im};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            s_ready_q   <= 1'b0;
            burst_cnt_q <= '0;
            di_en_q     <= 1'b0;
            di_re_q     <= '0;
            di_im_q     <= '0;
            out_cnt_q   <= '0;
            m_en_q      <= 1'b0;
            m_last_q    <= 1'b0;
            m_re_q      <= '0;
            m_im_q      <= '0;
            credits_q   <= 4'(CREDITS);
            inflight_q  <= 4'd0;
            err_q       <= 1'b0;
        end else begin
            fill_q     <= fill_d;
            s_ready_q  <= (fill_d < FW'(FIFO_DEPTH));
            credits_q  <= credits_d;
            inflight_q <= inflight_d;
            if (push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                di_re_q  <= rd_data[2*WIDTH-1:WIDTH];
                di_im_q  <= rd_data[WIDTH-1:0];
            end
            di_en_q <= pop;

            case (state_q)
                IDLE: begin
                    if (launch) begin
                        state_q     <= STREAM;
                        burst_cnt_q <= '0;
                    end
                end
                STREAM: begin
                    // Count wraps to 0 on its own, so a relaunch simply stays in STREAM.
                    burst_cnt_q <= burst_cnt_q + CW'(1);
                    if (last_pop && !launch)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            m_en_q   <= core_do_en;
            m_re_q   <= core_do_re;
            m_im_q   <= core_do_im;
            m_last_q <= frame_end;
            if (core_do_en)
                out_cnt_q <= out_cnt_q + CW'(1);
            else
                out_cnt_q <= '0;
            if (frame_abort)
                err_q <= 1'b1;
        end
    end

    assign strm.s_ready = s_ready_q;
    assign strm.m_en    = m_en_q;
    assign strm.m_last  = m_last_q;
    assign strm.m_re    = m_re_q;
    assign strm.m_im    = m_im_q;
    assign core_di_en   = di_en_q;
    assign core_di_re   = di_re_q;
    assign core_di_im   = di_im_q;
    assign credits      = credits_q;
    assign inflight     = inflight_q;
    assign busy         = (state_q == STREAM) || (inflight_q != 4'd0);
    assign err_frame    = err_q;
endmodule
